// File: rtl/fiber_stream_emitter.sv
// Transmit end of the sparse coord/pos stream protocol: walks [seg_start, seg_end) through a
// 1-cycle coordinate memory and emits lockstep data, stop and done tokens into two skid FIFOs.
module fiber_stream_emitter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              tile_en,
    input  logic [7:0]        stop_lvl,
    input  logic [ADDR_W-1:0] seg_start,
    input  logic [ADDR_W-1:0] seg_end,
    input  logic              seg_last,
    input  logic              seg_valid,
    output logic              seg_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W:0]   coord_out,
    output logic              coord_out_valid,
    input  logic              coord_out_ready,
    output logic [DATA_W:0]   pos_out,
    output logic              pos_out_valid,
    input  logic              pos_out_ready
);

    localparam int unsigned SW   = DATA_W + 1;
    localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StFetch, StStop, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, end_q, end_d, issued_q, issued_d;
    logic              last_q, last_d, inflight_q;

    logic [SW-1:0]     coord_mem_q [FIFO_DEPTH];
    logic [SW-1:0]     pos_mem_q   [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, coord_rd_q, pos_rd_q;
    logic [CntW-1:0]   coord_cnt_q, pos_cnt_q;

    logic              go, push, tok_push, credit_ok, coord_pop, pos_pop;
    logic [SW-1:0]     tok_val, coord_push_val, pos_push_val;
    logic [CntW:0]     coord_need, pos_need;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign go              = clk_en & tile_en;
    assign coord_out_valid = tile_en & (coord_cnt_q != '0);
    assign pos_out_valid   = tile_en & (pos_cnt_q != '0);
    assign coord_out       = coord_mem_q[coord_rd_q];
    assign pos_out         = pos_mem_q[pos_rd_q];
    assign coord_pop       = coord_out_valid & coord_out_ready & clk_en;
    assign pos_pop         = pos_out_valid & pos_out_ready & clk_en;

    // Entries draining this cycle free their slot, which sustains one token per cycle at depth 2.
    always_comb begin
        coord_need = (CntW+1)'(coord_cnt_q) + (CntW+1)'(inflight_q) - (CntW+1)'(coord_pop);
        pos_need   = (CntW+1)'(pos_cnt_q) + (CntW+1)'(inflight_q) - (CntW+1)'(pos_pop);
        credit_ok  = (coord_need < (CntW+1)'(FIFO_DEPTH)) && (pos_need < (CntW+1)'(FIFO_DEPTH));
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        end_d     = end_q;
        last_d    = last_q;
        issued_d  = issued_q;
        seg_ready = 1'b0;
        mem_ren   = 1'b0;
        mem_addr  = '0;
        tok_push  = 1'b0;
        tok_val   = '0;
        unique case (state_q)
            StIdle: begin
                seg_ready = go & ~rst;
                if (seg_valid) begin
                    ptr_d   = seg_start;
                    end_d   = seg_end;
                    last_d  = seg_last;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (ptr_q >= end_q) begin
                    state_d = StStop;
                end else if (credit_ok && go) begin
                    mem_ren  = 1'b1;
                    mem_addr = ptr_q;
                    issued_d = ptr_q;
                    ptr_d    = ptr_q + ADDR_W'(1);
                    if (ptr_q + ADDR_W'(1) == end_q) state_d = StStop;
                end
            end
            StStop: begin
                if (credit_ok && go && !inflight_q) begin
                    tok_push = 1'b1;
                    tok_val  = {1'b1, {(DATA_W-8){1'b0}}, stop_lvl};
                    state_d  = last_q ? StDone : StIdle;
                end
            end
            StDone: begin
                if (credit_ok && go) begin
                    tok_push = 1'b1;
                    tok_val  = {1'b1, DATA_W'(256)};
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read data and token pushes are mutually exclusive: tokens wait for inflight to clear.
    assign push           = go & (inflight_q | tok_push);
    assign coord_push_val = inflight_q ? {1'b0, mem_rdata} : tok_val;
    assign pos_push_val   = inflight_q ? {1'b0, DATA_W'(issued_q)} : tok_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            end_q      <= '0;
            last_q     <= 1'b0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
        end else if (clk_en && flush) begin
            state_q    <= StIdle;
            inflight_q <= 1'b0;
        end else if (go) begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            end_q      <= end_d;
            last_q     <= last_d;
            issued_q   <= issued_d;
            inflight_q <= mem_ren;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            coord_rd_q  <= '0;
            pos_rd_q    <= '0;
            coord_cnt_q <= '0;
            pos_cnt_q   <= '0;
        end else if (clk_en && flush) begin
            wr_ptr_q    <= '0;
            coord_rd_q  <= '0;
            pos_rd_q    <= '0;
            coord_cnt_q <= '0;
            pos_cnt_q   <= '0;
        end else if (clk_en) begin
            if (push)      wr_ptr_q   <= ptr_inc(wr_ptr_q);
            if (coord_pop) coord_rd_q <= ptr_inc(coord_rd_q);
            if (pos_pop)   pos_rd_q   <= ptr_inc(pos_rd_q);
            coord_cnt_q <= coord_cnt_q + CntW'(push) - CntW'(coord_pop);
            pos_cnt_q   <= pos_cnt_q + CntW'(push) - CntW'(pos_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && !flush && push) begin
            coord_mem_q[wr_ptr_q] <= coord_push_val;
            pos_mem_q[wr_ptr_q]   <= pos_push_val;
        end
    end

endmodule

// File: tb/tb_fiber_stream_emitter.sv
// Directed bench for fiber_stream_emitter: expected tokens are queued when a command is
// driven and popped as each stream hands a token over.
module tb_fiber_stream_emitter;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam logic [7:0]  LVL        = 8'h2a;
    localparam logic [16:0] STOP_TOK   = 17'h10000 | 17'(LVL);
    localparam logic [16:0] DONE_TOK   = 17'h10100;

    logic        clk, rst, clk_en, flush, tile_en;
    logic [7:0]  stop_lvl;
    logic [15:0] seg_start, seg_end;
    logic        seg_last, seg_valid, seg_ready;
    logic [15:0] mem_addr;
    logic        mem_ren;
    logic [15:0] mem_rdata;
    logic [16:0] coord_out, pos_out;
    logic        coord_out_valid, coord_out_ready, pos_out_valid, pos_out_ready;

    logic [15:0] mem [64];
    logic [16:0] exp_coord [$];
    logic [16:0] exp_pos [$];
    int          checks = 0;
    int          fails = 0;
    int          ren_cnt = 0;
    int          coord_tok_cnt = 0;
    int          pos_tok_cnt = 0;
    int          r0;

    fiber_stream_emitter #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .stop_lvl(stop_lvl), .seg_start(seg_start), .seg_end(seg_end), .seg_last(seg_last),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .mem_addr(mem_addr), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata), .coord_out(coord_out), .coord_out_valid(coord_out_valid),
        .coord_out_ready(coord_out_ready), .pos_out(pos_out), .pos_out_valid(pos_out_valid),
        .pos_out_ready(pos_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr[5:0]];

    always @(negedge clk) if (mem_ren) ren_cnt++;

    // Scoreboard side: compare every handed-over token and guard FIFO occupancy.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst) begin
            if (coord_out_valid && coord_out_ready) begin
                coord_tok_cnt++;
                checks++;
                assert (exp_coord.size() > 0) else begin
                    fails++; $error("FAIL coord_unexpected got=%h exp=none", coord_out);
                end
                if (exp_coord.size() > 0) begin
                    e = exp_coord.pop_front();
                    checks++;
                    assert (coord_out === e) else begin
                        fails++; $error("FAIL coord_tok got=%h exp=%h", coord_out, e);
                    end
                end
            end
            if (pos_out_valid && pos_out_ready) begin
                pos_tok_cnt++;
                checks++;
                assert (exp_pos.size() > 0) else begin
                    fails++; $error("FAIL pos_unexpected got=%h exp=none", pos_out);
                end
                if (exp_pos.size() > 0) begin
                    e = exp_pos.pop_front();
                    checks++;
                    assert (pos_out === e) else begin
                        fails++; $error("FAIL pos_tok got=%h exp=%h", pos_out, e);
                    end
                end
            end
            checks++;
            assert (32'(dut.coord_cnt_q) <= FIFO_DEPTH && 32'(dut.pos_cnt_q) <= FIFO_DEPTH)
            else begin
                fails++;
                $error("FAIL fifo_overflow got=%0d/%0d exp<=%0d", dut.coord_cnt_q,
                       dut.pos_cnt_q, FIFO_DEPTH);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++; $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int s, input int e, input bit last);
        for (int a = s; a < e; a++) begin
            exp_coord.push_back({1'b0, mem[a]});
            exp_pos.push_back(17'(a));
        end
        exp_coord.push_back(STOP_TOK);
        exp_pos.push_back(STOP_TOK);
        if (last) begin
            exp_coord.push_back(DONE_TOK);
            exp_pos.push_back(DONE_TOK);
        end
    endtask

    // Returns just after the accepting clock edge.
    task automatic issue(input int s, input int e, input bit last);
        int n = 0;
        seg_start = 16'(s);
        seg_end   = 16'(e);
        seg_last  = last;
        seg_valid = 1'b1;
        #1;
        while (!seg_ready && n < 100) begin
            step();
            n++;
        end
        chk("seg_accept_wait", 32'(seg_ready), 32'd1);
        step();
        seg_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle, input string tag);
        int n = 0;
        while ((exp_coord.size() != 0 || exp_pos.size() != 0) && n < 300) begin
            step();
            if (toggle) coord_out_ready = ~coord_out_ready;
            n++;
        end
        coord_out_ready = 1'b1;
        chk(tag, 32'(exp_coord.size() + exp_pos.size()), 32'd0);
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 7 + 100);
        mem[0] = 16'd1; mem[1] = 16'd8;
        mem[4] = 16'd3; mem[5] = 16'd9; mem[6] = 16'd12;
        rst = 1'b1; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1; stop_lvl = LVL;
        seg_start = '0; seg_end = '0; seg_last = 1'b0; seg_valid = 1'b0;
        coord_out_ready = 1'b1; pos_out_ready = 1'b1;

        step(); step();
        chk("rst_seg_ready", 32'(seg_ready), 32'd0);
        chk("rst_coord_valid", 32'(coord_out_valid), 32'd0);
        chk("rst_pos_valid", 32'(pos_out_valid), 32'd0);
        chk("rst_mem_ren", 32'(mem_ren), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_seg_ready", 32'(seg_ready), 32'd1);

        // Single fiber with first-valid latency.
        coord_tok_cnt = 0; pos_tok_cnt = 0; r0 = ren_cnt;
        push_exp(4, 7, 1'b1);
        issue(4, 7, 1'b1);
        step();
        chk("lat_valid_edge1", 32'(coord_out_valid), 32'd0);
        step();
        chk("lat_valid_edge2", 32'(coord_out_valid), 32'd1);
        drain(1'b0, "single_drain");
        chk("single_coord_cnt", 32'(coord_tok_cnt), 32'd5);
        chk("single_pos_cnt", 32'(pos_tok_cnt), 32'd5);
        chk("single_ren_cnt", 32'(ren_cnt - r0), 32'd3);

        // Empty fiber then one-element last fiber.
        coord_tok_cnt = 0; pos_tok_cnt = 0; r0 = ren_cnt;
        push_exp(5, 5, 1'b0);
        push_exp(0, 1, 1'b1);
        issue(5, 5, 1'b0);
        seg_start = 16'd0; seg_end = 16'd1; seg_last = 1'b1; seg_valid = 1'b1;
        #1;
        while (!seg_ready) step();
        chk("empty_no_ren", 32'(ren_cnt - r0), 32'd0);
        step();
        seg_valid = 1'b0;
        drain(1'b0, "empty_drain");
        chk("empty_coord_cnt", 32'(coord_tok_cnt), 32'd4);
        chk("empty_pos_cnt", 32'(pos_tok_cnt), 32'd4);
        chk("empty_ren_cnt", 32'(ren_cnt - r0), 32'd1);

        // Toggling coord ready, pos ready held high.
        coord_tok_cnt = 0; pos_tok_cnt = 0;
        push_exp(4, 7, 1'b1);
        issue(4, 7, 1'b1);
        drain(1'b1, "bp_drain");
        chk("bp_coord_cnt", 32'(coord_tok_cnt), 32'd5);
        chk("bp_pos_cnt", 32'(pos_tok_cnt), 32'd5);

        // Flush after the second data push of [0,8).
        coord_tok_cnt = 0; pos_tok_cnt = 0;
        for (int a = 0; a < 2; a++) begin
            exp_coord.push_back({1'b0, mem[a]});
            exp_pos.push_back(17'(a));
        end
        issue(0, 8, 1'b0);
        step(); step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_coord_valid", 32'(coord_out_valid), 32'd0);
        chk("flush_pos_valid", 32'(pos_out_valid), 32'd0);
        for (int i = 0; i < 5; i++) step();
        chk("flush_quiet_coord", 32'(coord_tok_cnt), 32'd2);
        chk("flush_quiet_pos", 32'(pos_tok_cnt), 32'd2);
        chk("flush_mem_ren", 32'(mem_ren), 32'd0);
        push_exp(0, 2, 1'b1);
        issue(0, 2, 1'b1);
        drain(1'b0, "post_flush_drain");
        chk("post_flush_coord_cnt", 32'(coord_tok_cnt), 32'd6);

        // Asynchronous reset mid-stream.
        push_exp(0, 8, 1'b1);
        issue(0, 8, 1'b1);
        step(); step(); step(); step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_coord_valid", 32'(coord_out_valid), 32'd0);
        chk("arst_pos_valid", 32'(pos_out_valid), 32'd0);
        chk("arst_mem_ren", 32'(mem_ren), 32'd0);
        exp_coord.delete();
        exp_pos.delete();
        step(); step();
        rst = 1'b0;
        #1;
        chk("arst_release_seg_ready", 32'(seg_ready), 32'd1);
        chk("arst_release_valid", 32'(coord_out_valid), 32'd0);

        // tile_en low blocks acceptance and reads.
        tile_en = 1'b0;
        seg_start = 16'd4; seg_end = 16'd6; seg_last = 1'b1; seg_valid = 1'b1;
        r0 = ren_cnt;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tile_off_seg_ready", 32'(seg_ready), 32'd0);
        end
        chk("tile_off_ren", 32'(ren_cnt - r0), 32'd0);
        push_exp(4, 6, 1'b1);
        tile_en = 1'b1;
        #1;
        chk("tile_on_seg_ready", 32'(seg_ready), 32'd1);
        step();
        seg_valid = 1'b0;
        drain(1'b0, "tile_on_drain");
        chk("tile_on_ren", 32'(ren_cnt - r0), 32'd2);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fiber_stream_emitter.md
Name: fiber_stream_emitter

Overview:
- Transmit end of the sparse coordinate/position stream protocol consumed by intersect_unit and the other sparse joiners.
- Accepts fiber segment commands as [seg_start, seg_end) pointer pairs and reads coordinates from a 1-cycle-latency coordinate memory.
- Emits lockstep 17-bit coord and pos streams with valid/ready handshakes, stop tokens after each fiber, and a done token after the last fiber.
- Sits between the memory-tile coordinate storage and joiner inputs, for example coord_in_0 and pos_in_0.

Parameters:
- ADDR_W, 16: pointer and memory address width.
- DATA_W, 16: coordinate payload width; stream width is DATA_W+1.
- FIFO_DEPTH, 2: entries per output skid FIFO (2..8).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- clk_en  in  1  when low, all state holds.
- flush  in  1  synchronous return to IDLE; FIFOs cleared.
- tile_en  in  1  when low, all valids/readys/mem_ren forced low and state holds.
- stop_lvl  in  8  level field placed in stop tokens.
- seg_start  in  ADDR_W  first pointer of the fiber, inclusive.
- seg_end  in  ADDR_W  end pointer of the fiber, exclusive.
- seg_last  in  1  this fiber is the final one of the tile.
- seg_valid  in  1  command valid.
- seg_ready  out  1  command accepted when seg_valid & seg_ready.
- mem_addr  out  ADDR_W  coordinate memory read address.
- mem_ren  out  1  read enable; data returns on mem_rdata the next cycle.
- mem_rdata  in  DATA_W  read data.
- coord_out  out  17  coordinate stream data.
- coord_out_valid  out  1  coordinate stream valid.
- coord_out_ready  in  1  coordinate stream ready.
- pos_out  out  17  position stream data.
- pos_out_valid  out  1  position stream valid.
- pos_out_ready  in  1  position stream ready.

Behaviour:
- Reset:
  - State is IDLE; FIFOs are empty; inflight=0.
  - All valids, seg_ready and mem_ren are 0; mem_addr is 0.
- Token encoding:
  - Data token: bit16=0, low bits = value.
  - Stop token: 17'h10000 | stop_lvl.
  - Done token: 17'h10100.
- Output FIFOs:
  - Each stream has its own FIFO, FIFO_DEPTH deep, first-word-fall-through.
  - out_valid = !empty.
  - A pop occurs on valid & ready, independently per stream.
  - Pushes are always paired: the same token index goes to both FIFOs in the same cycle.
- Credit rule:
  - A read or token push may issue only if count+inflight < FIFO_DEPTH for BOTH FIFOs.
  - inflight is 1 for the cycle after mem_ren.
  - Overflow is illegal and must be asserted against in the bench.
- State machine:
  - IDLE:
    - seg_ready=1.
    - On accept, latch ptr=seg_start, end=seg_end, last=seg_last, and go to FETCH.
  - FETCH:
    - If ptr>=end, go to STOP; this covers empty and inverted segments.
    - Otherwise, when credit allows, mem_ren=1, mem_addr=ptr, ptr++.
    - One cycle later push coord={0,mem_rdata} and pos={0,ptr_issued}; the pos value is zero-extended.
    - Go to STOP when ptr+1==end on the issuing cycle.
  - STOP:
    - When credit allows and no read is in flight, push the stop token to both FIFOs.
    - Then go to DONE if last, else IDLE.
  - DONE:
    - When credit allows, push the done token to both FIFOs.
    - Then go to IDLE.
- Throughput: one data token per cycle with both readys held high and FIFO_DEPTH>=2.
- Latency: seg accept to first coord_out_valid is 2 cycles (FETCH issue, then data push).
- Backpressure: a low coord_out_ready stalls both streams once its FIFO credit is exhausted. The other stream continues to drain its own FIFO.
- Pointer range: ptr is ADDR_W wide; seg_end up to 2^ADDR_W-1 is supported; wrap-around is not supported.
- Flush or reset mid-fiber:
  - Any in-flight read is discarded.
  - FIFOs are emptied the next cycle; no partial tokens are emitted.
- clk_en=0: state, FIFOs and inflight hold, and the mem_rdata capture is deferred. The memory must hold its output, as in the codebase memories.
- A new command is not accepted until the current fiber's stop (and done, if last) token has been pushed.

Test Plan:
- Single fiber: seg [4,7), mem[4..6]=3,9,12, seg_last=1, both readys=1.
  - coord_out = 3,9,12,0x10000|stop_lvl,0x10100.
  - pos_out = 4,5,6, stop, 0x10100.
  - First valid appears 2 cycles after accept.
- Empty fiber: seg [5,5), last=0, followed by seg [0,1) with last=1.
  - Streams are stop, mem[0], stop, done.
  - mem_ren is not pulsed for the empty fiber.
- Asymmetric backpressure: coord_out_ready toggles every cycle while pos_out_ready=1.
  - Both streams carry identical token sequences.
  - Neither FIFO overflows.
  - Token count is 5 on each stream for the single-fiber case.
- Flush mid-fiber: flush pulses after the 2nd data push of seg [0,8).
  - No further tokens appear.
  - Valids drop within 1 cycle.
  - The next command [0,2) with last=1 streams mem[0], mem[1], stop, done cleanly.
- Async reset asserted mid-stream: all valids and mem_ren drop immediately, without waiting for a clock edge. After release, seg_ready=1.
- tile_en=0 with seg_valid=1: seg_ready=0 and no reads. Raising tile_en resumes normal acceptance.
